// File: rtl/csr_exec.sv
// csr_exec -- multi-cycle executor for RISC-V Zicsr instructions
// (CSRRW/CSRRS/CSRRC and their immediate forms).
//
// Sequence per instruction: IDLE (accept) -> READ (sample CSR read bus)
// -> WRITE (one-cycle write strobe) -> RESP (hold result until taken).
// Fixed latency: accept at edge N, csr_we high N+1..N+2, rsp_valid from N+2.
//
// Optional feature macro: CSR_EXEC_RO_CHECK_EN
//   defined   : a write to read-only CSR space (addr[11:10] == 2'b11) is
//               flagged illegal and suppressed; pure reads there stay legal.
//   undefined : no address check; the CSR file decides whether to honour
//               the strobe. Only funct3 000/100 is illegal.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   req_valid/req_ready          issue handshake (ready only in IDLE)
//   req_funct3, req_csr_addr,
//   req_rs1_idx, req_rs1_val,
//   req_rd                       instruction fields, latched on accept
//   csr_raddr/csr_rdata          combinational read bus of the CSR file
//   csr_we/csr_waddr/csr_wdata   single-cycle write port to the CSR file
//   rsp_valid/rsp_ready          writeback handshake
//   rsp_rd, rsp_data,
//   rsp_illegal                  result: destination, old CSR value, flag
module csr_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_csr_addr,
  input  logic [4:0]      req_rs1_idx,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [4:0]      req_rd,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [4:0]      rsp_rd,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_illegal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched instruction fields; pure data, captured only on accept.
  logic [2:0]      funct3_q;
  logic [11:0]     addr_q;
  logic [4:0]      rs1_idx_q;
  logic [XLEN-1:0] rs1_val_q;
  logic [4:0]      rd_q;

  // Write decision taken at the READ->WRITE edge, qualifies csr_we in WRITE.
  logic            wr_q;

  logic [XLEN-1:0] src;
  logic            is_illegal;
  logic            wants_write;
  logic            write_ok;

  // Read-modify-write: op is funct3[1:0] (01 write, 10 set, 11 clear).
  function automatic logic [XLEN-1:0] csr_rmw(input logic [1:0]      op,
                                              input logic [XLEN-1:0] old_val,
                                              input logic [XLEN-1:0] src_val);
    case (op)
      2'b10:   csr_rmw = old_val | src_val;
      2'b11:   csr_rmw = old_val & ~src_val;
      default: csr_rmw = src_val;
    endcase
  endfunction

  // Operand selection and legality, all from the latched fields.
  always_comb begin
    src         = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_val_q;
    // Set/clear with rs1 = x0 (or zimm = 0) is a pure read.
    wants_write = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
    is_illegal  = (funct3_q[1:0] == 2'b00);
`ifdef CSR_EXEC_RO_CHECK_EN
    if (wants_write && (addr_q[11:10] == 2'b11)) begin
      is_illegal = 1'b1;
    end
`endif
    write_ok    = wants_write && !is_illegal;
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    csr_we    = 1'b0;
    csr_raddr = 12'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = READ;
        end
      end
      READ: begin
        csr_raddr = addr_q;
        state_nxt = WRITE;
      end
      WRITE: begin
        csr_raddr = addr_q;
        csr_we    = wr_q;
        state_nxt = RESP;
      end
      RESP: begin
        csr_raddr = addr_q;
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accept: latch the request so later input changes are ignored
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      funct3_q  <= req_funct3;
      addr_q    <= req_csr_addr;
      rs1_idx_q <= req_rs1_idx;
      rs1_val_q <= req_rs1_val;
      rd_q      <= req_rd;
    end
  end

  // READ -> WRITE: sample the old value, form write data and the response.
  // Response fields are then held unchanged through WRITE and RESP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q        <= 1'b0;
      csr_waddr   <= 12'd0;
      csr_wdata   <= '0;
      rsp_rd      <= 5'd0;
      rsp_data    <= '0;
      rsp_illegal <= 1'b0;
    end else if (state == READ) begin
      wr_q        <= write_ok;
      csr_waddr   <= addr_q;
      csr_wdata   <= csr_rmw(funct3_q[1:0], csr_rdata, src);
      rsp_rd      <= rd_q;
      rsp_data    <= is_illegal ? '0 : csr_rdata;
      rsp_illegal <= is_illegal;
    end
  end

endmodule
